// File: rtl/ascon_pack.sv
// Shared ASCON types and constants: state type, forward/inverse S-box tables,
// column parallelism and the FSM encoding used by the inverse substitution layer.
package ascon_pack;

    typedef logic [4:0][63:0] type_state;

    localparam int unsigned COLS_PER_CYCLE = 8;

    localparam logic [4:0] SBOX_TABLE [32] = '{
        5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
        5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
        5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
        5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
    };

    localparam logic [4:0] INV_TABLE [32] = '{
        5'h14, 5'h1A, 5'h07, 5'h0D, 5'h00, 5'h09, 5'h0E, 5'h12,
        5'h0A, 5'h06, 5'h1D, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1E,
        5'h18, 5'h16, 5'h0B, 5'h11, 5'h03, 5'h05, 5'h1C, 5'h1F,
        5'h17, 5'h1B, 5'h04, 5'h08, 5'h0F, 5'h0C, 5'h10, 5'h02
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } inv_fsm_t;

endpackage

// File: rtl/inv_sbox_layer_if.sv
// Handshake/data bundle between a producer (master) and inv_sbox_layer (slave).
interface inv_sbox_layer_if;

    ascon_pack::type_state state_i;
    logic                  valid_i;
    logic                  ready_o;
    ascon_pack::type_state state_o;
    logic                  valid_o;
    logic                  ready_i;
    logic                  err_o;

    modport slave (
        input  state_i, valid_i, ready_i,
        output ready_o, state_o, valid_o, err_o
    );

    modport master (
        output state_i, valid_i, ready_i,
        input  ready_o, state_o, valid_o, err_o
    );

endinterface

// File: rtl/inv_sbox_layer_sbox_inv.sv
// Inverse ASCON 5-bit S-box, combinational table lookup.
module sbox_inv
    import ascon_pack::*;
(
    input  logic [4:0] x_i,
    output logic [4:0] y_o
);

    always_comb begin
        y_o = INV_TABLE[x_i];
    end

endmodule

// File: rtl/sbox.sv
// Forward ASCON 5-bit S-box, combinational table lookup.
module sbox
    import ascon_pack::*;
(
    input  logic [4:0] x_i,
    output logic [4:0] y_o
);

    always_comb begin
        y_o = SBOX_TABLE[x_i];
    end

endmodule

// File: rtl/inv_sbox_layer.sv
// Iterative inverse ASCON substitution layer, 8 columns per cycle, in place.
// Optional forward-S-box self-check enabled by macro SBOX_INV_CHECK_EN.
module inv_sbox_layer
    import ascon_pack::*;
(
    input  logic               clock_i,
    input  logic               reset_i,
    inv_sbox_layer_if.slave    bus
);

    inv_fsm_t  state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    type_state work_q, work_d;
    logic      valid_q, valid_d;

    logic [4:0] col_in  [COLS_PER_CYCLE];
    logic [4:0] col_out [COLS_PER_CYCLE];

    // Column j of the current slice is x0[j]..x4[j], x0 as MSB.
    always_comb begin
        for (int unsigned i = 0; i < COLS_PER_CYCLE; i++) begin
            logic [5:0] j;
            j = {cnt_q, 3'(i)};
            for (int unsigned b = 0; b < 5; b++) begin
                col_in[i][4-b] = work_q[b][j];
            end
        end
    end

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_inv
        sbox_inv u_inv (
            .x_i (col_in[g]),
            .y_o (col_out[g])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        valid_d = valid_q;
        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                if (bus.valid_i) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    work_d  = bus.state_i;
                end
            end
            ST_RUN: begin
                for (int unsigned i = 0; i < COLS_PER_CYCLE; i++) begin
                    logic [5:0] j;
                    j = {cnt_q, 3'(i)};
                    for (int unsigned b = 0; b < 5; b++) begin
                        work_d[b][j] = col_out[i][4-b];
                    end
                end
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // valid_o rises one cycle after entering DONE and drops on handshake.
                if (valid_q && bus.ready_i) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end else begin
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            valid_q <= valid_d;
        end
    end

    assign bus.ready_o = (state_q == ST_IDLE);
    assign bus.valid_o = valid_q;
    assign bus.state_o = work_q;

`ifdef SBOX_INV_CHECK_EN
    logic [4:0]                col_fwd [COLS_PER_CYCLE];
    logic [COLS_PER_CYCLE-1:0] chk_bad;
    logic                      err_q;

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_chk
        sbox u_chk (
            .x_i (col_out[g]),
            .y_o (col_fwd[g])
        );
        assign chk_bad[g] = (col_fwd[g] != col_in[g]);
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            err_q <= 1'b0;
        end else if (state_q == ST_IDLE && bus.valid_i) begin
            err_q <= 1'b0;
        end else if (state_q == ST_RUN && (|chk_bad)) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err_o = err_q;
`else
    assign bus.err_o = 1'b0;
`endif

endmodule

// File: doc/inv_sbox_layer.md
INV_SBOX_LAYER -- requirements
Module: inv_sbox_layer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clock_i, reset_i.
REQ-002 SHALL have port clock_i, input, 1 bit: rising-edge clock.
REQ-003 SHALL have port reset_i, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port state_i, input, type_state (5 x 64 bits): state to be inverse-substituted.
REQ-005 SHALL have port valid_i, input, 1 bit: state_i is valid.
REQ-006 SHALL have port ready_o, output, 1 bit: block accepts state_i.
REQ-007 SHALL have port state_o, output, type_state: inverse-substituted state.
REQ-008 SHALL have port valid_o, output, 1 bit: state_o is valid.
REQ-009 SHALL have port ready_i, input, 1 bit: downstream accepts state_o.
REQ-010 SHALL have port err_o, output, 1 bit: sticky self-check mismatch flag.

Function
REQ-011 SHALL define column j (0..63) as the 5-bit value {x0[j],x1[j],x2[j],x3[j]} followed by x4[j], with x0 as the MSB, and SHALL map each column c through the inverse ASCON S-box, INV[c].
REQ-012 SHALL use this INV table, listed for inputs 00..1F: 14 1A 07 0D 00 09 0E 12 0A 06 1D 01 19 15 13 1E 18 16 0B 11 03 05 1C 1F 17 1B 04 08 0F 0C 10 02 (hex).
REQ-013 SHALL implement a three-state FSM: IDLE -> RUN on valid_i&ready_o; RUN -> DONE when the column counter completes; DONE -> IDLE on valid_o&ready_i.
REQ-014 SHALL assert ready_o only in IDLE; SHALL capture state_i into the working register on the accept cycle.
REQ-015 SHALL process 8 columns per cycle in RUN, using columns 8k..8k+7 at counter value k; the counter is 3 bits, runs 0..7 and wraps to 0 on leaving RUN.
REQ-016 SHALL write results in place into the working register; state_o SHALL be that register.
REQ-017 SHALL assert valid_o exactly 9 cycles after the accept edge (8 RUN cycles + 1 registered transition), and only in DONE.
REQ-018 SHALL hold state_o and valid_o stable while valid_o=1 and ready_i=0, for any number of cycles.
REQ-019 SHALL ignore valid_i outside IDLE; the captured data SHALL NOT change.
REQ-020 SHALL NOT accept a new input in the cycle in which an output handshake completes; the next accept occurs in IDLE at the earliest.

Reset
REQ-021 SHALL, on reset_i=1 at a clock edge, force FSM=IDLE, counter=0, working register=0, valid_o=0, ready_o=1 (from the following cycle), and err_o=0.
REQ-022 SHALL abandon any operation in progress on reset in RUN or DONE; partial results SHALL never appear with valid_o=1.

Configuration
REQ-023 SHALL, with macro SBOX_INV_CHECK_EN defined, pass each of the 8 per-cycle results through the forward S-box and compare them with the original column; any mismatch SHALL set err_o, which stays set until the next accept or reset.
REQ-024 SHALL, without SBOX_INV_CHECK_EN, tie err_o to 0 and instantiate no forward S-boxes.

Structure
REQ-025 SHALL take type_state from ascon_pack; the INV table constant and COLS_PER_CYCLE=8 SHALL be added to ascon_pack.
REQ-026 SHALL use one sub-module, sbox_inv (5-bit in, 5-bit out, combinational INV lookup), instantiated 8 times; the check path SHALL reuse the existing forward sbox module.

Verification
REQ-027 SHALL verify: all-zero state in, ready_i=1 -> after 9 cycles valid_o=1, x0=x2=FFFFFFFFFFFFFFFF, x1=x3=x4=0.
REQ-028 SHALL verify: all-ones state in -> x3=FFFFFFFFFFFFFFFF, x0=x1=x2=x4=0.
REQ-029 SHALL verify round trip: random state passed through the forward substitution layer then through this block -> state_o equals the original state; err_o=0 with SBOX_INV_CHECK_EN defined.
REQ-030 SHALL verify backpressure: ready_i=0 for 5 cycles in DONE -> state_o/valid_o unchanged; ready_i=1 -> valid_o=0 and ready_o=1 on the following cycle.
REQ-031 SHALL verify reset mid-RUN at counter=3 -> next cycle FSM=IDLE, valid_o=0, ready_o=1, state_o=0.
REQ-032 SHALL verify exhaustive columns: 32 states, each with every column = v (00..1F) -> every output column = INV[v].
